// File: rtl/eth_tx_framer_pkg.sv
// Shared definitions for the Ethernet TX framer: FSM states, CRC-32 constants, default lengths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package eth_tx_framer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAD  = 2'd2,
        S_FCS  = 2'd3
    } state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    localparam int DEF_MIN_LEN = 60;
    localparam int DEF_MAX_LEN = 1514;

    // Binary to Gray, so counters can be sampled safely from another clock domain.
    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Next-state of a reflected CRC-32 after one byte, bit0 first.
// Latency: combinational.
// Backpressure: none; caller decides when to register the result.
module eth_crc32_d8
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Shift the byte in LSB first, matching the transmit bit order on the wire.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Frames a byte stream into the TX FIFO: truncates at MAX_LEN, zero-pads to MIN_LEN (ETH_TX_PAD_EN), appends FCS with EOD.
// Latency: FIFO write one cycle after the accepting/generating cycle; next frame accepted >= 6 cycles after in_last.
// Backpressure: fifo_afull stalls everything (no write, no state/CRC change); in_ready is low outside S_DATA.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int MIN_LEN = DEF_MIN_LEN
) (
    input  logic        REF_CLK,
    input  logic        arst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  fifo_din,
    output logic        fifo_EOD_in,
    output logic        fifo_wren,
    input  logic        fifo_afull,
    output logic [15:0] frame_count_gray,
    output logic [15:0] oversize_count_gray
);

    localparam int              CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [31:0]      crc, crc_nxt, fcs_sh;
    logic             oversize;
    logic [1:0]       fcs_idx;
    logic [15:0]      frame_cnt, over_cnt;

    logic             wr_en, wr_eod, crc_upd, cnt_inc, over_set, fcs_adv, frame_done;
    logic [7:0]       wr_dat;

    // FCS is the inverted CRC, emitted least-significant byte first.
    assign fcs_sh = (~crc) >> {fcs_idx, 3'b000};

    // The CRC always absorbs exactly the byte being written (data or pad zero).
    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (wr_dat),
        .crc_out (crc_nxt)
    );

    // State register.
    always_ff @(posedge REF_CLK or posedge arst) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accept handshake and write intent for this cycle.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_dat     = 8'h00;
        wr_eod     = 1'b0;
        crc_upd    = 1'b0;
        cnt_inc    = 1'b0;
        over_set   = 1'b0;
        fcs_adv    = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_DATA;
            end
            S_DATA: begin
                in_ready = ~fifo_afull;
                if (in_valid && !fifo_afull) begin
                    // Bytes past MAX_LEN are swallowed so the source can finish its burst.
                    if (count < MAX_C) begin
                        wr_en   = 1'b1;
                        wr_dat  = in_data;
                        crc_upd = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        over_set = 1'b1;
                    end
                    if (in_last) begin
                        state_nxt = (PAD_EN && ((count + ONE_C) < MIN_C)) ? S_PAD : S_FCS;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                if (!fifo_afull) begin
                    wr_en   = 1'b1;
                    crc_upd = 1'b1;
                    cnt_inc = 1'b1;
                    if ((count + ONE_C) == MIN_C) begin
                        state_nxt = S_FCS;
                    end
                end
            end
`endif
            S_FCS: begin
                if (!fifo_afull) begin
                    wr_en   = 1'b1;
                    wr_dat  = fcs_sh[7:0];
                    fcs_adv = 1'b1;
                    if (fcs_idx == 2'd3) begin
                        wr_eod     = 1'b1;
                        frame_done = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-frame datapath: byte count, running CRC, oversize flag, FCS byte index.
    always_ff @(posedge REF_CLK or posedge arst) begin
        if (arst) begin
            count    <= '0;
            crc      <= CRC32_INIT;
            oversize <= 1'b0;
            fcs_idx  <= 2'd0;
        end else if (state == S_IDLE) begin
            count    <= '0;
            crc      <= CRC32_INIT;
            oversize <= 1'b0;
            fcs_idx  <= 2'd0;
        end else begin
            if (crc_upd)  crc      <= crc_nxt;
            if (cnt_inc)  count    <= count + ONE_C;
            if (over_set) oversize <= 1'b1;
            if (fcs_adv)  fcs_idx  <= fcs_idx + 2'd1;
        end
    end

    // Frame statistics; Gray copies are registered so the outputs never glitch.
    always_ff @(posedge REF_CLK or posedge arst) begin
        if (arst) begin
            frame_cnt           <= 16'd0;
            over_cnt            <= 16'd0;
            frame_count_gray    <= 16'd0;
            oversize_count_gray <= 16'd0;
        end else if (frame_done) begin
            frame_cnt        <= frame_cnt + 16'd1;
            frame_count_gray <= bin2gray(frame_cnt + 16'd1);
            if (oversize) begin
                over_cnt            <= over_cnt + 16'd1;
                oversize_count_gray <= bin2gray(over_cnt + 16'd1);
            end
        end
    end

    // Registered FIFO write port.
    always_ff @(posedge REF_CLK or posedge arst) begin
        if (arst) begin
            fifo_wren   <= 1'b0;
            fifo_din    <= 8'h00;
            fifo_EOD_in <= 1'b0;
        end else begin
            fifo_wren   <= wr_en;
            fifo_din    <= wr_dat;
            fifo_EOD_in <= wr_eod;
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: frames are modelled from byte lists and checked as the DUT writes them.
// Latency: n/a.
// Backpressure: bench drives fifo_afull both deterministically and randomly.
module tb_eth_tx_framer;

    localparam int MAXL = 1514;
    localparam int MINL = 60;

    logic        REF_CLK = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  fifo_din;
    logic        fifo_EOD_in;
    logic        fifo_wren;
    logic        fifo_afull = 1'b0;
    logic [15:0] frame_count_gray;
    logic [15:0] oversize_count_gray;

    eth_tx_framer dut (
        .REF_CLK             (REF_CLK),
        .arst                (arst),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_last             (in_last),
        .in_ready            (in_ready),
        .fifo_din            (fifo_din),
        .fifo_EOD_in         (fifo_EOD_in),
        .fifo_wren           (fifo_wren),
        .fifo_afull          (fifo_afull),
        .frame_count_gray    (frame_count_gray),
        .oversize_count_gray (oversize_count_gray)
    );

    always #5 REF_CLK = ~REF_CLK;

    int cyc = 0;
    always @(posedge REF_CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_dat[$];
    logic       exp_eod[$];
    logic [7:0] wr_log[$];
    logic       eod_log[$];
    int         exp_frames = 0;
    int         exp_over   = 0;
    int         first_cyc  = 0;
    int         last_cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Standard software CRC-32 (reflected, init all-ones, final inversion).
    function automatic logic [31:0] sw_crc32(input logic [7:0] f[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (f[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ f[i][b]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Reference: what the FIFO must receive for a frame offered as d.
    task automatic push_frame(input logic [7:0] d[$]);
        logic [7:0]  f[$];
        logic [31:0] fcs;
        for (int i = 0; i < d.size() && i < MAXL; i++) f.push_back(d[i]);
`ifdef ETH_TX_PAD_EN
        while (f.size() < MINL) f.push_back(8'h00);
`endif
        fcs = sw_crc32(f);
        foreach (f[i]) begin
            exp_dat.push_back(f[i]);
            exp_eod.push_back(1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            exp_dat.push_back(fcs[8*k +: 8]);
            exp_eod.push_back(k == 3);
        end
        exp_frames++;
        if (d.size() > MAXL) exp_over++;
    endtask

    // Monitor: every FIFO write is matched against the head of the scoreboard.
    always @(negedge REF_CLK) begin
        if (!arst && fifo_wren) begin
            wr_log.push_back(fifo_din);
            eod_log.push_back(fifo_EOD_in);
            if (exp_dat.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", fifo_din);
            end else begin
                chk("wr_data", fifo_din, exp_dat.pop_front());
                chk("wr_eod", fifo_EOD_in, exp_eod.pop_front());
            end
        end
    end

    task automatic do_stall(input logic [7:0] d[$], input int i);
        for (int k = 0; k < 10; k++) begin
            @(negedge REF_CLK);
            fifo_afull = 1'b1;
            in_valid   = 1'b1;
            in_data    = d[i];
            in_last    = (i == d.size() - 1);
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            if (k >= 1) chk("stall_wren", fifo_wren, 1'b0);
        end
    endtask

    task automatic do_abort();
        @(negedge REF_CLK);
        #1;
        arst       = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        fifo_afull = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_wren", fifo_wren, 1'b0);
        chk("abort_din", fifo_din, 8'h00);
        chk("abort_eod", fifo_EOD_in, 1'b0);
        chk("abort_frames", frame_count_gray, 16'h0);
        chk("abort_over", oversize_count_gray, 16'h0);
        chk("abort_pending", exp_dat.size(), 0);
        exp_frames = 0;
        exp_over   = 0;
        @(posedge REF_CLK);
        @(negedge REF_CLK);
        arst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d[$], input int stall_at, input int abort_at, input bit rnd);
        int i;
        int loops;
        bit acc;
        i = 0;
        loops = 0;
        while (i < d.size()) begin
            @(negedge REF_CLK);
            loops++;
            if (loops > 20 * d.size() + 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: accepted %0d expected %0d", i, d.size());
                break;
            end
            in_data    = d[i];
            in_last    = (i == d.size() - 1);
            in_valid   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            fifo_afull = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
            #1;
            if (rnd && fifo_afull) chk("afull_in_ready", in_ready, 1'b0);
            acc = in_valid & in_ready;
            if (acc && i == 0) first_cyc = cyc;
            if (acc && in_last) last_cyc = cyc;
            @(posedge REF_CLK);
            if (acc) begin
                i++;
                if (i == stall_at) do_stall(d, i);
                if (i == abort_at) begin
                    do_abort();
                    return;
                end
            end
        end
        @(negedge REF_CLK);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        fifo_afull = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_dat.size() != 0 && n < 5000) begin
            @(negedge REF_CLK);
            n++;
        end
        repeat (2) @(negedge REF_CLK);
        chk(name, exp_dat.size(), 0);
    endtask

    task automatic check_counters(input string name);
        chk({name, "_frames"}, g2b(frame_count_gray), exp_frames);
        chk({name, "_over"}, g2b(oversize_count_gray), exp_over);
    endtask

    task automatic rand_bytes(output logic [7:0] d[$], input int n);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] d2[$];
        int gap;

        // Reset values.
        repeat (3) @(negedge REF_CLK);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wren", fifo_wren, 1'b0);
        chk("rst_din", fifo_din, 8'h00);
        chk("rst_eod", fifo_EOD_in, 1'b0);
        chk("rst_frames", frame_count_gray, 16'h0);
        chk("rst_over", oversize_count_gray, 16'h0);
        arst = 1'b0;

        // "123456789": the classic CRC-32 check string.
        d.delete();
        for (int k = 0; k < 9; k++) d.push_back(8'h31 + 8'(k));
        wr_log.delete();
        eod_log.delete();
        push_frame(d);
        send_frame(d, -1, -1, 1'b0);
        wait_drain("t1_drain");
`ifdef ETH_TX_PAD_EN
        chk("t1_writes", wr_log.size(), 64);
`else
        chk("t1_writes", wr_log.size(), 13);
        chk("t1_fcs0", wr_log[9], 8'h26);
        chk("t1_fcs1", wr_log[10], 8'h39);
        chk("t1_fcs2", wr_log[11], 8'hF4);
        chk("t1_fcs3", wr_log[12], 8'hCB);
        chk("t1_eod13", eod_log[12], 1'b1);
`endif
        check_counters("t1");

        // Short frame: padded to 60 when padding is built in.
        rand_bytes(d, 14);
        wr_log.delete();
        eod_log.delete();
        push_frame(d);
        send_frame(d, -1, -1, 1'b0);
        wait_drain("t2_drain");
`ifdef ETH_TX_PAD_EN
        chk("t2_writes", wr_log.size(), 64);
`else
        chk("t2_writes", wr_log.size(), 18);
`endif

        // Stall of 10 cycles after byte 20 of a 100-byte frame.
        rand_bytes(d, 100);
        wr_log.delete();
        eod_log.delete();
        push_frame(d);
        send_frame(d, 20, -1, 1'b0);
        wait_drain("t3_drain");
        chk("t3_writes", wr_log.size(), 104);

        // Oversize: 1600 bytes offered, 1514 written.
        rand_bytes(d, 1600);
        wr_log.delete();
        eod_log.delete();
        push_frame(d);
        send_frame(d, -1, -1, 1'b0);
        wait_drain("t4_drain");
        chk("t4_writes", wr_log.size(), 1518);
        check_counters("t4");

        // Reset mid-frame after byte 20, then a clean frame.
        rand_bytes(d, 50);
        for (int i = 0; i < 20; i++) begin
            exp_dat.push_back(d[i]);
            exp_eod.push_back(1'b0);
        end
        send_frame(d, -1, 20, 1'b0);
        rand_bytes(d, 64);
        push_frame(d);
        send_frame(d, -1, -1, 1'b0);
        wait_drain("t5_drain");
        check_counters("t5");

        // Two 60-byte frames back to back.
        rand_bytes(d, 60);
        rand_bytes(d2, 60);
        wr_log.delete();
        eod_log.delete();
        push_frame(d);
        push_frame(d2);
        send_frame(d, -1, -1, 1'b0);
        gap = last_cyc;
        send_frame(d2, -1, -1, 1'b0);
        gap = first_cyc - gap;
        wait_drain("t6_drain");
        chk("t6_writes", wr_log.size(), 128);
        chk("t6_eod64", eod_log[63], 1'b1);
        chk("t6_eod128", eod_log[127], 1'b1);
        total++;
        if (gap < 6) begin
            bad++;
            $display("FAIL t6_gap: got %0d cycles expected at least 6", gap);
        end
        check_counters("t6");

        // Random lengths with random valid gaps and random afull.
        for (int f = 0; f < 8; f++) begin
            rand_bytes(d, $urandom_range(1, 300));
            push_frame(d);
            send_frame(d, -1, -1, 1'b1);
        end
        wait_drain("t7_drain");
        check_counters("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
